// File: rtl/fp_mult_pkg.sv
// Shared constants and types for the single-precision multiplier datapath.
package fp_mult_pkg;

  localparam int MANT_W = 25;  // [24]=hidden 1, [23:1]=fraction, [0]=guard
  localparam int FRAC_W = 23;
  localparam int EXP_W  = 10;  // signed biased exponent, two's complement
  localparam int SH_W   = 5;
  localparam int BIAS   = 127;

  localparam logic [7:0]  EXP_INF = 8'hFF;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  // Stage-1 register contents: rounded fraction, adjusted exponent, flags
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [FRAC_W-1:0] frac;
    logic             inx;
    logic             nan;
    logic             inf;
    logic             zero;
  } s1_t;

endpackage

// File: rtl/rne_rounder.sv
// Round-to-nearest-even on the normalized mantissa; purely combinational.
module rne_rounder
  import fp_mult_pkg::*;
(
  input  logic [MANT_W-1:0] mant,
  input  logic              sticky,
  output logic [MANT_W-1:0] sig,
  output logic              carry,
  output logic              inexact
);

  logic round_up;

  // ties go to even: round only when guard set and (sticky or odd lsb)
  assign round_up = mant[0] & (sticky | mant[1]);
  assign sig      = {1'b0, mant[MANT_W-1:1]} + {{(MANT_W-1){1'b0}}, round_up};
  assign carry    = sig[MANT_W-1];
  assign inexact  = mant[0] | sticky;

endmodule

// File: rtl/fp_round_pack.sv
// Multiplier final stage: exponent adjust + RNE round (stage 1),
// exception handling + binary32 pack (stage 2). Valid/ready, no bubbles.
module fp_round_pack
  import fp_mult_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic signed [EXP_W-1:0] in_exp,
  input  logic [SH_W-1:0]         in_shamt,
  input  logic [MANT_W-1:0]       in_mant,
  input  logic                    in_sticky,
  input  logic                    in_nan,
  input  logic                    in_inf,
  input  logic                    in_zero,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_data,
  output logic                    out_ovf,
  output logic                    out_unf,
  output logic                    out_inx
);

  localparam int STAGES = 2;
  localparam logic [EXP_W-1:0] EXP_OVF = EXP_W'(255);
  localparam logic [EXP_W-1:0] EXP_ZERO = '0;

  logic [STAGES:1]   vld_pipe;
  logic              rdy1, rdy2;
  logic [MANT_W-1:0] sig;
  logic              carry, inexact;
  s1_t               s1_d, s1_q;
  logic [31:0]       pk_data;
  logic              pk_ovf, pk_unf, pk_inx;

  assign rdy2      = ~vld_pipe[2] | out_ready;
  assign rdy1      = ~vld_pipe[1] | rdy2;
  assign in_ready  = rdy1;
  assign out_valid = vld_pipe[2];

  rne_rounder u_rnd (
    .mant    (in_mant),
    .sticky  (in_sticky),
    .sig     (sig),
    .carry   (carry),
    .inexact (inexact)
  );

  // stage 1: undo the normalization shift, fold in rounding carry
  always_comb begin
    s1_d.sign = in_sign;
    s1_d.exp  = in_exp - {{(EXP_W-SH_W){1'b0}}, in_shamt}
                       + {{(EXP_W-1){1'b0}}, carry};
    s1_d.frac = carry ? '0 : sig[FRAC_W-1:0];
    s1_d.inx  = inexact;
    s1_d.nan  = in_nan;
    s1_d.inf  = in_inf;
    s1_d.zero = in_zero;
  end

  // stage 2: exception priority nan > inf > zero > overflow > underflow > normal
  always_comb begin
    pk_data = {s1_q.sign, s1_q.exp[7:0], s1_q.frac};
    pk_ovf  = 1'b0;
    pk_unf  = 1'b0;
    pk_inx  = s1_q.inx;
    if (s1_q.nan) begin
      pk_data = QNAN;
      pk_inx  = 1'b0;
    end else if (s1_q.inf) begin
      pk_data = {s1_q.sign, EXP_INF, {FRAC_W{1'b0}}};
      pk_inx  = 1'b0;
    end else if (s1_q.zero) begin
      pk_data = {s1_q.sign, 31'h0};
      pk_inx  = 1'b0;
    end else if ($signed(s1_q.exp) >= $signed(EXP_OVF)) begin
      pk_data = {s1_q.sign, EXP_INF, {FRAC_W{1'b0}}};
      pk_ovf  = 1'b1;
      pk_inx  = 1'b1;
    end else if ($signed(s1_q.exp) <= $signed(EXP_ZERO)) begin
      pk_data = {s1_q.sign, 31'h0};
      pk_unf  = 1'b1;
      pk_inx  = 1'b1;
    end
  end

  // pipeline registers; each stage advances only when its successor can take it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      out_data <= '0;
      out_ovf  <= 1'b0;
      out_unf  <= 1'b0;
      out_inx  <= 1'b0;
    end else begin
      if (rdy1) vld_pipe[1] <= in_valid;
      if (in_valid && rdy1) s1_q <= s1_d;
      if (rdy2) vld_pipe[2] <= vld_pipe[1];
      if (vld_pipe[1] && rdy2) begin
        out_data <= pk_data;
        out_ovf  <= pk_ovf;
        out_unf  <= pk_unf;
        out_inx  <= pk_inx;
      end
    end
  end

endmodule

// File: tb/tb_fp_round_pack.sv
// Bench for fp_round_pack: directed vectors, behavioural model + scoreboard.
module tb_fp_round_pack;
  import fp_mult_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, in_valid, in_ready, in_sign, in_sticky;
  logic              in_nan, in_inf, in_zero;
  logic signed [9:0] in_exp;
  logic [4:0]        in_shamt;
  logic [24:0]       in_mant;
  logic              out_valid, out_ready, out_ovf, out_unf, out_inx;
  logic [31:0]       out_data;

  fp_round_pack dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_shamt(in_shamt), .in_mant(in_mant),
    .in_sticky(in_sticky), .in_nan(in_nan), .in_inf(in_inf), .in_zero(in_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .out_unf(out_unf), .out_inx(out_inx)
  );

  typedef struct {
    logic sign; logic [9:0] exp; logic [4:0] shamt; logic [24:0] mant;
    logic sticky; logic nan; logic inf; logic zero;
  } beat_t;
  typedef struct { logic [31:0] data; logic ovf; logic unf; logic inx; } res_t;

  int    tests = 0;
  int    fails = 0;
  res_t  exp_q[$];
  beat_t vq[$];
  res_t  lq[$];

  // IEEE-style reference: integer significand, round half to even, flush denormals
  function automatic res_t model(beat_t b);
    res_t r;
    int   e, q;
    bit   g;
    r.data = 32'h0; r.ovf = 0; r.unf = 0; r.inx = 0;
    if (b.nan)       r.data = 32'h7FC0_0000;
    else if (b.inf)  r.data = {b.sign, 8'hFF, 23'h0};
    else if (b.zero) r.data = {b.sign, 31'h0};
    else begin
      e = int'($signed(b.exp)) - int'(b.shamt);
      q = int'(b.mant >> 1);
      g = b.mant[0];
      if (g && (b.sticky || (q % 2 == 1))) q = q + 1;
      if (q == (1 << 24)) begin q = 1 << 23; e = e + 1; end
      if (e >= 255) begin
        r.data = {b.sign, 8'hFF, 23'h0}; r.ovf = 1; r.inx = 1;
      end else if (e <= 0) begin
        r.data = {b.sign, 31'h0}; r.unf = 1; r.inx = 1;
      end else begin
        r.data = {b.sign, e[7:0], q[22:0]};
        r.inx  = g | b.sticky;
      end
    end
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic addv(logic s, int e, int sh, logic [24:0] m, logic st, logic n, logic i,
                      logic z, logic [31:0] d, logic ov, logic un, logic ix);
    beat_t b; res_t r;
    b.sign = s; b.exp = 10'(e); b.shamt = 5'(sh); b.mant = m;
    b.sticky = st; b.nan = n; b.inf = i; b.zero = z;
    r.data = d; r.ovf = ov; r.unf = un; r.inx = ix;
    vq.push_back(b); lq.push_back(r);
  endtask

  task automatic drive(beat_t b);
    in_valid = 1; in_sign = b.sign; in_exp = b.exp; in_shamt = b.shamt;
    in_mant = b.mant; in_sticky = b.sticky; in_nan = b.nan; in_inf = b.inf; in_zero = b.zero;
  endtask

  // returns just after the accepting edge with in_valid dropped
  task automatic wait_accept(string name);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1 in_valid = 0;
        return;
      end
      @(posedge clk);
    end
    tests++; fails++;
    $display("FAIL %s accept timeout in_ready=%0b want=1", name, in_ready);
    #1 in_valid = 0;
  endtask

  // scoreboard: every accepted beat must emerge once, in order, held while stalled
  logic [34:0] hold;
  bit          stalled = 0;
  always @(negedge clk) begin
    beat_t b;
    if (!rst_n) begin
      exp_q.delete();
      stalled = 0;
    end else begin
      if (stalled) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_data", {out_data, out_ovf, out_unf, out_inx}, hold);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL spurious_out got=%0h want=none", out_data);
        end else begin
          chk("out", {out_data, out_ovf, out_unf, out_inx},
              {exp_q[0].data, exp_q[0].ovf, exp_q[0].unf, exp_q[0].inx});
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        b.sign = in_sign; b.exp = in_exp; b.shamt = in_shamt; b.mant = in_mant;
        b.sticky = in_sticky; b.nan = in_nan; b.inf = in_inf; b.zero = in_zero;
        exp_q.push_back(model(b));
      end
      stalled = out_valid && !out_ready;
      hold    = {out_data, out_ovf, out_unf, out_inx};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit");
    $fatal(1);
  end

  initial begin
    res_t r;
    rst_n = 0; in_valid = 0; out_ready = 1; in_sign = 0; in_exp = 0; in_shamt = 0;
    in_mant = 0; in_sticky = 0; in_nan = 0; in_inf = 0; in_zero = 0;

    //    s  exp sh  mant          st n i z   data          ov un ix
    addv(0, 127, 0, 25'h100_0000, 0, 0,0,0, 32'h3F80_0000, 0, 0, 0);
    addv(0, 127, 0, 25'h100_0001, 0, 0,0,0, 32'h3F80_0000, 0, 0, 1);
    addv(0, 127, 0, 25'h100_0003, 0, 0,0,0, 32'h3F80_0002, 0, 0, 1);
    addv(0, 127, 0, 25'h1FF_FFFF, 0, 0,0,0, 32'h4000_0000, 0, 0, 1);
    addv(0, 130, 3, 25'h100_0000, 0, 0,0,0, 32'h3F80_0000, 0, 0, 0);
    addv(0, 300, 0, 25'h100_0000, 0, 0,0,0, 32'h7F80_0000, 1, 0, 1);
    addv(1,   2, 5, 25'h100_0000, 0, 0,0,0, 32'h8000_0000, 0, 1, 1);
    addv(0, 127, 0, 25'h100_0000, 0, 1,1,0, 32'h7FC0_0000, 0, 0, 0);
    addv(1, 127, 0, 25'h100_0000, 0, 0,1,0, 32'hFF80_0000, 0, 0, 0);
    addv(1, 127, 0, 25'h100_0000, 0, 0,0,1, 32'h8000_0000, 0, 0, 0);
    addv(0, 127, 0, 25'h100_0000, 1, 0,0,0, 32'h3F80_0000, 0, 0, 1);
    addv(0, 127, 0, 25'h100_0001, 1, 0,0,0, 32'h3F80_0001, 0, 0, 1);
    addv(0, 254, 0, 25'h1FF_FFFF, 0, 0,0,0, 32'h7F80_0000, 1, 0, 1);
    addv(0,   1, 0, 25'h100_0000, 0, 0,0,0, 32'h0080_0000, 0, 0, 0);
    addv(0,   1, 1, 25'h100_0000, 0, 0,0,0, 32'h0000_0000, 0, 1, 1);
    addv(0, 254, 0, 25'h100_0000, 0, 0,0,0, 32'h7F00_0000, 0, 0, 0);

    // hand-computed expectations pin the reference model
    foreach (vq[i]) begin
      r = model(vq[i]);
      chk($sformatf("model_%0d", i), {r.data, r.ovf, r.unf, r.inx},
          {lq[i].data, lq[i].ovf, lq[i].unf, lq[i].inx});
    end

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", {out_data, out_ovf, out_unf, out_inx}, 0);
    rst_n = 1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);

    // single beat latency
    drive(vq[0]); wait_accept("lat");
    chk("lat_edge1_valid", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_edge2_valid", out_valid, 1);
    chk("lat_edge2_data", out_data, 32'h3F80_0000);
    @(posedge clk); #1;

    // all vectors back to back at full rate
    foreach (vq[i]) begin
      drive(vq[i]); wait_accept($sformatf("vec_%0d", i));
    end
    repeat (4) @(posedge clk);
    #1;

    // backpressure: two beats fill the pipe, third waits
    out_ready = 0;
    drive(vq[1]); wait_accept("bp_a");
    drive(vq[2]); wait_accept("bp_b");
    drive(vq[3]);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready_low", in_ready, 0);
      @(posedge clk);
    end
    #1 out_ready = 1;
    wait_accept("bp_c");
    drive(vq[5]); wait_accept("bp_d");
    repeat (4) @(posedge clk);
    #1;
    chk("bp_drained", exp_q.size(), 0);

    // reset with two beats in flight
    out_ready = 0;
    drive(vq[3]); wait_accept("rf_a");
    drive(vq[6]); wait_accept("rf_b");
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1; out_ready = 1;
    chk("rf_out_valid", out_valid, 0);
    chk("rf_out_data", out_data, 0);
    chk("rf_in_ready", in_ready, 1);
    drive(vq[4]); wait_accept("rf_post");
    chk("rf_post_edge1", out_valid, 0);
    @(posedge clk); #1;
    chk("rf_post_edge2", out_valid, 1);
    chk("rf_post_data", out_data, 32'h3F80_0000);
    repeat (3) @(posedge clk);
    #1;
    chk("final_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
